// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared phase codes, FSM states and defaults for the conv block sequencer
package conv_pkg;

    localparam int N_DEFAULT = 2;

    // {eop,sop} phase codes seen by the memory control unit and conv units
    localparam logic [1:0] PH_LOAD = 2'b00;
    localparam logic [1:0] PH_PROC = 2'b01;
    localparam logic [1:0] PH_OUT  = 2'b10;
    localparam logic [1:0] PH_IDLE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PROC,
        ST_OUT,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/wrap_counter.sv
// rtl/wrap_counter.sv - enable-gated counter with programmable terminal value and wrap flag
module wrap_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] q,
    output logic         wrap
);

    assign wrap = en && (q == last);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= wrap ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/conv_block_sequencer.sv
// rtl/conv_block_sequencer.sv - LOAD/PROC/OUT phase sequencer driving bank rotation and row address
module conv_block_sequencer
    import conv_pkg::*;
#(
    parameter int N      = N_DEFAULT,
    parameter int ADDR_W = 10,
    parameter int COLS_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_img_h,
    input  logic [COLS_W-1:0] i_img_w,
    input  logic              i_px_valid,
    output logic              o_px_ready,
    output logic              o_sop,
    output logic              o_eop,
    output logic              o_chblk,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_proc_start,
    input  logic              i_proc_done,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_cfg_err
);

    localparam int                UNIT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [COLS_W-1:0] N_C       = COLS_W'(N);
    localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(N - 1);

    seq_state_t        state;
    logic [1:0]        phase;
    logic [ADDR_W-1:0] h_m1, h_m3, addr_last;
    logic [COLS_W-1:0] w_m2, cols_last, out_cols;
    logic [COLS_W-1:0] unused_col_cnt;
    logic [UNIT_W-1:0] unused_unit_cnt;
    logic              accept, start_bad;
    logic              load_beat, out_beat;
    logic              addr_wrap, col_wrap, unit_wrap;

    assign o_sop = phase[0];
    assign o_eop = phase[1];

    assign accept    = (state == ST_IDLE) && i_start;
    assign start_bad = (i_img_h < ADDR_W'(3)) || (i_img_w < COLS_W'(N + 2)) ||
                       (((i_img_w - COLS_W'(2)) % N_C) != '0);

    assign load_beat = (state == ST_LOAD) && o_px_ready && i_px_valid;
    assign out_beat  = (state == ST_OUT) && o_out_valid && i_out_ready;
    // Loads sweep the full column; results skip the two border rows of each unit
    assign addr_last = (state == ST_OUT) ? h_m3 : h_m1;

    wrap_counter #(.W(ADDR_W)) u_row (
        .clk(clk), .rst(rst), .clr(accept), .en(load_beat || out_beat),
        .last(addr_last), .q(o_addr), .wrap(addr_wrap)
    );

    wrap_counter #(.W(COLS_W)) u_col (
        .clk(clk), .rst(rst), .clr(accept), .en(load_beat && addr_wrap),
        .last(cols_last), .q(unused_col_cnt), .wrap(col_wrap)
    );

    wrap_counter #(.W(UNIT_W)) u_unit (
        .clk(clk), .rst(rst), .clr(accept), .en(out_beat && addr_wrap),
        .last(UNIT_LAST), .q(unused_unit_cnt), .wrap(unit_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            phase        <= PH_IDLE;
            o_px_ready   <= 1'b0;
            o_chblk      <= 1'b0;
            o_proc_start <= 1'b0;
            o_out_valid  <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_cfg_err    <= 1'b0;
            h_m1         <= '0;
            h_m3         <= '0;
            w_m2         <= '0;
            cols_last    <= '0;
            out_cols     <= '0;
        end else begin
            o_chblk      <= 1'b0;
            o_proc_start <= 1'b0;
            o_frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        h_m1 <= i_img_h - ADDR_W'(1);
                        h_m3 <= i_img_h - ADDR_W'(3);
                        w_m2 <= i_img_w - COLS_W'(2);
                        if (start_bad) begin
                            o_cfg_err <= 1'b1;
                        end else begin
                            o_cfg_err  <= 1'b0;
                            cols_last  <= COLS_W'(N + 1);
                            out_cols   <= '0;
                            state      <= ST_LOAD;
                            phase      <= PH_LOAD;
                            o_px_ready <= 1'b1;
                            o_busy     <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (addr_wrap) o_chblk <= 1'b1;
                    if (col_wrap) begin
                        state        <= ST_PROC;
                        phase        <= PH_PROC;
                        o_px_ready   <= 1'b0;
                        o_proc_start <= 1'b1;
                    end
                end
                ST_PROC: begin
                    // A done arriving alongside the start pulse belongs to no job
                    if (!o_proc_start && i_proc_done) begin
                        state       <= ST_OUT;
                        phase       <= PH_OUT;
                        o_out_valid <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (addr_wrap) begin
                        o_chblk <= 1'b1;
                        if (unit_wrap) begin
                            o_out_valid <= 1'b0;
                            out_cols    <= out_cols + N_C;
                            if (out_cols + N_C == w_m2) begin
                                state        <= ST_DONE;
                                phase        <= PH_IDLE;
                                o_frame_done <= 1'b1;
                            end else begin
                                // Two overlap columns stay resident, so only N new ones load
                                cols_last  <= COLS_W'(N - 1);
                                state      <= ST_LOAD;
                                phase      <= PH_LOAD;
                                o_px_ready <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_block_sequencer.sv
// tb/tb_conv_block_sequencer.sv - scoreboard bench for conv_block_sequencer
module tb_conv_block_sequencer;

    localparam int N  = 2;
    localparam int AW = 10;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [AW-1:0] i_img_h;
    logic [CW-1:0] i_img_w;
    logic          i_px_valid;
    logic          o_px_ready, o_sop, o_eop, o_chblk;
    logic [AW-1:0] o_addr;
    logic          o_proc_start, i_proc_done;
    logic          o_out_valid, i_out_ready;
    logic          o_busy, o_frame_done, o_cfg_err;

    always #5 clk = ~clk;

    conv_block_sequencer #(.N(N), .ADDR_W(AW), .COLS_W(CW)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_img_h(i_img_h), .i_img_w(i_img_w),
        .i_px_valid(i_px_valid), .o_px_ready(o_px_ready), .o_sop(o_sop), .o_eop(o_eop),
        .o_chblk(o_chblk), .o_addr(o_addr), .o_proc_start(o_proc_start),
        .i_proc_done(i_proc_done), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_cfg_err(o_cfg_err)
    );

    typedef struct {
        int addr;
        bit wrap;
    } beat_t;

    beat_t load_q[$];
    beat_t out_q[$];
    int    frames_exp = 0;
    int    n_chk = 0;
    int    n_fail = 0;

    int    valid_mode = 0;
    int    ready_mode = 0;
    bit    proc_early = 0;
    int    proc_delay = 5;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: frame = (w-2)/N blocks; first block loads N+2 columns, later ones N;
    // each block emits N units of h-2 rows; every column/unit end rotates the banks.
    task automatic push_frame(input int h, input int w);
        int blocks;
        blocks = (w - 2) / N;
        for (int b = 0; b < blocks; b++) begin
            for (int c = 0; c < ((b == 0) ? N + 2 : N); c++)
                for (int r = 0; r < h; r++) load_q.push_back('{r, r == h - 1});
            for (int u = 0; u < N; u++)
                for (int r = 0; r < h - 2; r++) out_q.push_back('{r, r == h - 3});
        end
        frames_exp++;
    endtask

    task automatic check_reset();
        check("rst_sop", o_sop, 1);
        check("rst_eop", o_eop, 1);
        check("rst_px_ready", o_px_ready, 0);
        check("rst_out_valid", o_out_valid, 0);
        check("rst_addr", o_addr, 0);
        check("rst_chblk", o_chblk, 0);
        check("rst_proc_start", o_proc_start, 0);
        check("rst_busy", o_busy, 0);
        check("rst_frame_done", o_frame_done, 0);
        check("rst_cfg_err", o_cfg_err, 0);
    endtask

    task automatic start(input int h, input int w);
        i_img_h = AW'(h);
        i_img_w = CW'(w);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (o_busy && k < 200) begin
            step();
            k++;
        end
        check("idle_timeout", o_busy, 0);
    endtask

    task automatic wait_frame();
        int k;
        k = 0;
        while (frames_exp > 0 && k < 8000) begin
            step();
            k++;
        end
        check("frame_timeout", frames_exp, 0);
        check("load_q_empty", load_q.size(), 0);
        check("out_q_empty", out_q.size(), 0);
    endtask

    task automatic run_frame(input int h, input int w);
        wait_idle();
        push_frame(h, w);
        start(h, w);
        check("start_cfg_err", o_cfg_err, 0);
        check("start_busy", o_busy, 1);
        wait_frame();
    endtask

    // Source and sink drivers
    initial begin
        i_px_valid  = 1'b0;
        i_out_ready = 1'b0;
        forever begin
            step();
            i_px_valid  = (valid_mode == 0) ? 1'b1 : 1'($urandom % 2);
            case (ready_mode)
                0:       i_out_ready = 1'b1;
                1:       i_out_ready = ~i_out_ready;
                default: i_out_ready = 1'($urandom % 2);
            endcase
        end
    end

    // Convolution engine model: done arrives d cycles after the start pulse
    initial begin
        int d;
        i_proc_done = 1'b0;
        forever begin
            step();
            if (o_proc_start && !rst) begin
                d = (proc_delay > 0) ? proc_delay : int'($urandom_range(1, 6));
                for (int k = 0; k < d; k++) begin
                    i_proc_done = proc_early && (k == 0);
                    step();
                end
                i_proc_done = 1'b1;
                step();
                i_proc_done = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every DUT beat and checks phase rules
    bit         exp_chblk = 0;
    int         proc_exp = 0;
    logic [1:0] prev_ph = 2'b11;

    always @(negedge clk) begin : mon
        logic [1:0] ph;
        beat_t      b;
        ph = {o_eop, o_sop};
        if (rst) begin
            exp_chblk = 0;
            proc_exp  = 0;
            prev_ph   = 2'b11;
        end else begin
            check("chblk", o_chblk, exp_chblk);
            exp_chblk = 0;
            if (proc_exp == 1) check("proc_hold", ph, 2'b01);
            if (proc_exp == 2) check("proc_to_out", ph, 2'b10);
            proc_exp = 0;
            if (ph == 2'b01) begin
                check("proc_start_first", o_proc_start, prev_ph != 2'b01);
                proc_exp = (i_proc_done && !o_proc_start) ? 2 : 1;
            end else begin
                check("proc_start_off", o_proc_start, 0);
            end
            check("px_ready_phase", o_px_ready, ph == 2'b00);
            check("out_valid_phase", o_out_valid, ph == 2'b10);
            if (ph != 2'b11) check("busy_phase", o_busy, 1);
            if (o_px_ready && i_px_valid) begin
                check("load_expected", load_q.size() > 0, 1);
                if (load_q.size() > 0) begin
                    b = load_q.pop_front();
                    check("load_addr", o_addr, b.addr);
                    exp_chblk = b.wrap;
                end
            end
            if (o_out_valid && i_out_ready) begin
                check("out_expected", out_q.size() > 0, 1);
                if (out_q.size() > 0) begin
                    b = out_q.pop_front();
                    check("out_addr", o_addr, b.addr);
                    exp_chblk = b.wrap;
                end
            end
            if (o_frame_done) begin
                check("frame_done_expected", frames_exp > 0, 1);
                check("frame_done_drained", load_q.size() + out_q.size(), 0);
                if (frames_exp > 0) frames_exp--;
            end
            prev_ph = ph;
        end
    end

    initial begin
        int h, w, k;
        rst     = 1'b1;
        i_start = 1'b0;
        i_img_h = '0;
        i_img_w = '0;
        repeat (3) step();
        check_reset();
        rst = 1'b0;
        step();

        // Nominal frame, everything ready
        run_frame(4, 6);

        // Sink stalls every other cycle
        ready_mode = 1;
        run_frame(4, 6);
        ready_mode = 0;

        // Geometry rejects
        wait_idle();
        start(2, 6);
        check("cfg_err_h", o_cfg_err, 1);
        check("cfg_err_h_busy", o_busy, 0);
        step();
        check("cfg_err_h_stay", o_busy, 0);
        start(4, 7);
        check("cfg_err_w_mod", o_cfg_err, 1);
        start(4, 3);
        check("cfg_err_w_min", o_cfg_err, 1);
        run_frame(3, 4);

        // Done coincident with proc_start must be ignored
        proc_early = 1;
        proc_delay = 3;
        run_frame(5, 8);
        proc_early = 0;
        proc_delay = 5;

        // Start pulse during LOAD has no effect
        wait_idle();
        push_frame(4, 6);
        start(4, 6);
        repeat (3) step();
        check("load_active", o_px_ready, 1);
        i_img_h = AW'(7);
        i_img_w = CW'(3);
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check("start_in_load_cfg", o_cfg_err, 0);
        wait_frame();

        // Reset in the middle of OUT aborts without frame_done
        wait_idle();
        push_frame(4, 6);
        start(4, 6);
        k = 0;
        while (!o_out_valid && k < 2000) begin
            step();
            k++;
        end
        check("reached_out", o_out_valid, 1);
        rst = 1'b1;
        load_q.delete();
        out_q.delete();
        frames_exp = 0;
        step();
        check_reset();
        rst = 1'b0;
        repeat (5) step();
        run_frame(4, 6);

        // Randomized geometry and handshakes
        for (int f = 0; f < 6; f++) begin
            h          = int'($urandom_range(3, 9));
            w          = 2 + N * int'($urandom_range(1, 3));
            valid_mode = int'($urandom_range(0, 1));
            ready_mode = int'($urandom_range(0, 2));
            proc_early = 1'($urandom % 2);
            proc_delay = 0;
            run_frame(h, w);
        end

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_block_sequencer.md
Name: conv_block_sequencer

Overview:
Top-level sequencer for the 2D convolution datapath. It walks an image through repeated LOAD -> PROC -> OUT phases and drives the {eop,sop} phase code, bank-rotation pulse (chblk) and row address consumed by the memory control unit and N convolution units. It handshakes with the pixel source, the convolution engine and the output sink, and signals end of frame.

Parameters:
N, 2, number of convolution units; N+2 column banks in rotation.
ADDR_W, 10, row address width; column height up to 2^ADDR_W.
COLS_W, 10, image width counter width.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_start  in  1  start-of-frame pulse, honoured only in IDLE
i_img_h  in  ADDR_W  rows per column, latched on accepted start
i_img_w  in  COLS_W  image columns, latched on accepted start
i_px_valid  in  1  pixel write strobe from source
o_px_ready  out  1  sequencer accepts pixels (LOAD only)
o_sop  out  1  phase code bit 0
o_eop  out  1  phase code bit 1
o_chblk  out  1  one-cycle bank-rotation pulse
o_addr  out  ADDR_W  row address for current column write/read
o_proc_start  out  1  one-cycle pulse starting convolution
i_proc_done  in  1  convolution finished
o_out_valid  out  1  result word available (OUT only)
i_out_ready  in  1  sink accepts result
o_busy  out  1  not IDLE
o_frame_done  out  1  one-cycle end-of-frame pulse
o_cfg_err  out  1  last start rejected for bad geometry

Behaviour:
- Phase code {eop,sop}: LOAD=00, PROC=01, OUT=10, IDLE/DONE=11 (datapath write-disable).
- Reset: FSM IDLE, o_sop=o_eop=1, every other output 0, all counters 0. rst mid-frame aborts immediately; no frame_done.
- FSM states: IDLE, LOAD, PROC, OUT, DONE.
- IDLE: on i_start, latch h/w. If h<3 or w<N+2 or (w-2) mod N != 0, set o_cfg_err=1, stay IDLE. Otherwise clear o_cfg_err, go LOAD with cols_to_load=N+2 and out_cols=0.
- LOAD: o_px_ready=1. Beat = i_px_valid&&o_px_ready. Each beat advances o_addr.
  - On a beat with o_addr==h-1: o_addr wraps to 0, o_chblk pulses the next cycle, and the loaded-column count increments.
  - When the loaded count reaches cols_to_load, the next state is PROC and the ready drop is registered (no extra beat is accepted).
- PROC: o_proc_start is high only in the first PROC cycle. i_proc_done is sampled from the second PROC cycle on; a done coinciding with proc_start is ignored. On done, go OUT with o_addr=0 and unit=0.
- OUT: o_out_valid=1. Beat = o_out_valid&&i_out_ready. The sink stalls freely.
  - o_addr counts 0..h-3 per unit. On the last row of a unit: o_addr wraps, o_chblk pulses, unit increments.
  - After unit N-1: out_cols += N.
  - If out_cols==w-2, go DONE. Otherwise go LOAD with cols_to_load=N (2-column overlap kept in banks).
- DONE: o_frame_done is high for 1 cycle, then IDLE.
- i_start is ignored outside IDLE. o_busy is 1 in every state except IDLE.
- Arithmetic: all counters unsigned, compared against latched h-1, h-3 and w-2 computed once at start.

Decomposition:
- Shared package conv_pkg holds the phase-code constants (LOAD/PROC/OUT/IDLE), the FSM state typedef and the default N.
- One natural sub-module, wrap_counter: a parameterised width, enable-gated counter with programmable terminal value and a wrap flag. It is instanced for the row address, column and unit counters.

Test Plan:
1. N=2, h=4, w=6, all ready/valid tied high:
   - LOAD of 16 beats with chblk after beats 4/8/12/16, then PROC.
   - done 5 cycles later, then OUT of 4 beats (addr 0,1,0,1) with 2 chblk pulses.
   - LOAD of 8 beats, PROC, OUT of 4 beats, then frame_done; total out beats 8.
2. Backpressure: same frame with i_out_ready toggling 1010… -> o_addr advances only on beats, 8 result beats total, no dropped or duplicated addresses.
3. Config errors:
   - h=2, w=6 -> cfg_err=1, FSM stays IDLE, busy=0.
   - w=7 -> cfg_err=1.
   - A following valid start clears cfg_err.
4. i_proc_done asserted in the same cycle as proc_start -> ignored. Sequencer stays in PROC until done arrives in a later cycle.
5. rst asserted mid-OUT -> next cycle sop=eop=1, out_valid=0, addr=0, no frame_done. A restart then runs the full frame normally.
6. i_start pulsed during LOAD -> no effect on counters or latched geometry.
